// File: rtl/keypad_pkg.sv
// Purpose : shared key codes, FSM state/command encodings and the multi-tap letter table.
// Latency : n/a (declarations and one pure lookup function).
// Backpressure: n/a.
// Contents: KEY_* codes ({row,col}, one-hot, row0/col0 = 4'b1000), state_e, cmd_e,
//           ASCII_UNDERSCORE, key_info_t and key_lookup().
package keypad_pkg;

  // Letter keys
  localparam logic [7:0] KEY_R0C1 = 8'h84;  // ABC
  localparam logic [7:0] KEY_R0C2 = 8'h82;  // DEF
  localparam logic [7:0] KEY_R1C0 = 8'h48;  // GHI
  localparam logic [7:0] KEY_R1C1 = 8'h44;  // JKL
  localparam logic [7:0] KEY_R1C2 = 8'h42;  // MNO
  localparam logic [7:0] KEY_R2C0 = 8'h28;  // PQRS
  localparam logic [7:0] KEY_R2C1 = 8'h24;  // TUV
  localparam logic [7:0] KEY_R2C2 = 8'h22;  // WXYZ
  // Command keys
  localparam logic [7:0] KEY_R3C0 = 8'h18;  // commit letter
  localparam logic [7:0] KEY_R3C1 = 8'h14;  // clear
  localparam logic [7:0] KEY_R3C2 = 8'h12;  // submit word
  localparam logic [7:0] KEY_R2C3 = 8'h21;  // game end
  localparam logic [7:0] KEY_R3C3 = 8'h11;  // backspace

  localparam logic [7:0] ASCII_UNDERSCORE = 8'h5F;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TAP     = 2'd1,
    ST_LCOMMIT = 2'd2,
    ST_WCOMMIT = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_COMMIT = 3'd1,
    CMD_CLEAR  = 3'd2,
    CMD_SUBMIT = 3'd3,
    CMD_END    = 3'd4,
    CMD_BKSP   = 3'd5
  } cmd_e;

  typedef struct packed {
    logic       is_letter;
    logic [7:0] base;   // ASCII of the first letter on the key
    logic [2:0] size;   // 3 or 4 letters on the key
    cmd_e       cmd;
  } key_info_t;

  // Anything not listed (including non-one-hot codes) decodes to "nothing".
  function automatic key_info_t key_lookup(input logic [7:0] key);
    key_info_t r;
    r.is_letter = 1'b0;
    r.base      = 8'h00;
    r.size      = 3'd0;
    r.cmd       = CMD_NONE;
    case (key)
      KEY_R0C1: begin r.is_letter = 1'b1; r.base = 8'h41; r.size = 3'd3; end
      KEY_R0C2: begin r.is_letter = 1'b1; r.base = 8'h44; r.size = 3'd3; end
      KEY_R1C0: begin r.is_letter = 1'b1; r.base = 8'h47; r.size = 3'd3; end
      KEY_R1C1: begin r.is_letter = 1'b1; r.base = 8'h4A; r.size = 3'd3; end
      KEY_R1C2: begin r.is_letter = 1'b1; r.base = 8'h4D; r.size = 3'd3; end
      KEY_R2C0: begin r.is_letter = 1'b1; r.base = 8'h50; r.size = 3'd4; end
      KEY_R2C1: begin r.is_letter = 1'b1; r.base = 8'h54; r.size = 3'd3; end
      KEY_R2C2: begin r.is_letter = 1'b1; r.base = 8'h57; r.size = 3'd4; end
      KEY_R3C0: r.cmd = CMD_COMMIT;
      KEY_R3C1: r.cmd = CMD_CLEAR;
      KEY_R3C2: r.cmd = CMD_SUBMIT;
      KEY_R2C3: r.cmd = CMD_END;
      KEY_R3C3: r.cmd = CMD_BKSP;
      default:  r.cmd = CMD_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keypad_tap_decode.sv
// Purpose : decode a raw {row,col} key code into letter-key info or a command code.
// Latency : combinational, zero cycles.
// Backpressure: none; pure function of cur_key.
// Ports   : cur_key in; is_letter, base (ASCII), size (3/4), cmd out.
module keypad_tap_decode
  import keypad_pkg::*;
(
  input  logic [7:0] cur_key,
  output logic       is_letter,
  output logic [7:0] base,
  output logic [2:0] size,
  output cmd_e       cmd
);

  key_info_t info;

  always_comb begin
    info      = key_lookup(cur_key);
    is_letter = info.is_letter;
    base      = info.base;
    size      = info.size;
    cmd       = info.cmd;
  end

endmodule

// File: rtl/multitap_word_entry.sv
// Purpose : multi-tap keypad text entry: builds letters from repeated key taps, collects them into a word.
// Latency : preview updates one cycle after a strobe; letter/word outputs are registered.
// Backpressure: letter_valid/word_valid hold until letter_ready/word_ready; strobes other than
//               clear/game-end are ignored while a handshake is pending.
// Ports   : clk, nRst, strobe, cur_key in; preview out; letter_valid/letter_ready/letter;
//           word_valid/word_ready/word/word_len; game_end pulse.
module multitap_word_entry
  import keypad_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int MAX_LEN        = 8
) (
  input  logic                         clk,
  input  logic                         nRst,
  input  logic                         strobe,
  input  logic [7:0]                   cur_key,
  output logic [7:0]                   preview,
  output logic                         letter_valid,
  input  logic                         letter_ready,
  output logic [7:0]                   letter,
  output logic                         word_valid,
  input  logic                         word_ready,
  output logic [8*MAX_LEN-1:0]         word,
  output logic [$clog2(MAX_LEN+1)-1:0] word_len,
  output logic                         game_end
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic       dec_is_letter;
  logic [7:0] dec_base;
  logic [2:0] dec_size;
  cmd_e       dec_cmd;

  keypad_tap_decode u_dec (
    .cur_key   (cur_key),
    .is_letter (dec_is_letter),
    .base      (dec_base),
    .size      (dec_size),
    .cmd       (dec_cmd)
  );

  state_e               state_q, state_d;
  logic [7:0]           preview_q, preview_d;
  logic [7:0]           letter_q, letter_d;
  logic [8*MAX_LEN-1:0] word_q, word_d;
  logic [LW-1:0]        len_q, len_d;
  logic                 game_end_q, game_end_d;
  logic [CW-1:0]        idle_cnt_q, idle_cnt_d;
  logic [7:0]           cand_key_q, cand_key_d;
  logic [7:0]           cand_base_q, cand_base_d;
  logic [2:0]           cand_size_q, cand_size_d;
  logic [1:0]           tap_idx_q, tap_idx_d;
  logic                 pend_vld_q, pend_vld_d;
  logic [7:0]           pend_key_q, pend_key_d;
  logic [7:0]           pend_base_q, pend_base_d;
  logic [2:0]           pend_size_q, pend_size_d;
  logic                 submit_after_q, submit_after_d;

  logic       key_ok;
  logic       do_commit;
  logic [1:0] tap_idx_nxt;
  logic [7:0] cand_letter;

  assign cand_letter = cand_base_q + {6'b0, tap_idx_q};
  // Wrap the tap index at the key's set size (3 or 4 letters).
  assign tap_idx_nxt = (({1'b0, tap_idx_q} + 3'd1) == cand_size_q) ? 2'd0 : tap_idx_q + 2'd1;

  always_comb begin
    state_d        = state_q;
    preview_d      = preview_q;
    letter_d       = letter_q;
    word_d         = word_q;
    len_d          = len_q;
    game_end_d     = 1'b0;
    idle_cnt_d     = idle_cnt_q;
    cand_key_d     = cand_key_q;
    cand_base_d    = cand_base_q;
    cand_size_d    = cand_size_q;
    tap_idx_d      = tap_idx_q;
    pend_vld_d     = pend_vld_q;
    pend_key_d     = pend_key_q;
    pend_base_d    = pend_base_q;
    pend_size_d    = pend_size_q;
    submit_after_d = submit_after_q;
    do_commit      = 1'b0;
    key_ok         = strobe && (dec_is_letter || (dec_cmd != CMD_NONE));

    if (key_ok && ((dec_cmd == CMD_CLEAR) || (dec_cmd == CMD_END))) begin
      // Clear and game end win in every state and abandon any pending handshake.
      state_d        = ST_IDLE;
      preview_d      = ASCII_UNDERSCORE;
      word_d         = '0;
      len_d          = '0;
      idle_cnt_d     = '0;
      tap_idx_d      = '0;
      pend_vld_d     = 1'b0;
      submit_after_d = 1'b0;
      game_end_d     = (dec_cmd == CMD_END);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (key_ok) begin
            if (dec_is_letter) begin
              state_d     = ST_TAP;
              cand_key_d  = cur_key;
              cand_base_d = dec_base;
              cand_size_d = dec_size;
              tap_idx_d   = '0;
              preview_d   = dec_base;
              idle_cnt_d  = '0;
            end else if ((dec_cmd == CMD_BKSP) && (len_q != '0)) begin
              for (int i = 0; i < MAX_LEN; i++) begin
                if ((LW'(i) + LW'(1)) == len_q) word_d[8*i +: 8] = 8'h00;
              end
              len_d = len_q - LW'(1);
            end else if ((dec_cmd == CMD_SUBMIT) && (len_q != '0)) begin
              state_d = ST_WCOMMIT;
            end
          end
        end

        ST_TAP: begin
          if (key_ok) begin
            idle_cnt_d = '0;
            if (dec_is_letter) begin
              if (cur_key == cand_key_q) begin
                tap_idx_d = tap_idx_nxt;
                preview_d = cand_base_q + {6'b0, tap_idx_nxt};
              end else begin
                // Different letter key: flush current candidate, then resume with this one.
                do_commit   = 1'b1;
                pend_vld_d  = 1'b1;
                pend_key_d  = cur_key;
                pend_base_d = dec_base;
                pend_size_d = dec_size;
              end
            end else if (dec_cmd == CMD_COMMIT) begin
              do_commit = 1'b1;
            end else if (dec_cmd == CMD_SUBMIT) begin
              do_commit      = 1'b1;
              submit_after_d = 1'b1;
            end else if (dec_cmd == CMD_BKSP) begin
              state_d   = ST_IDLE;
              preview_d = ASCII_UNDERSCORE;
              tap_idx_d = '0;
            end
          end else if ((TIMEOUT_CYCLES != 0) && (idle_cnt_q == TO_LAST)) begin
            do_commit = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + CW'(1);
          end
        end

        ST_LCOMMIT: begin
          if (letter_ready) begin
            for (int i = 0; i < MAX_LEN; i++) begin
              if (LW'(i) == len_q) word_d[8*i +: 8] = letter_q;
            end
            len_d     = len_q + LW'(1);
            preview_d = ASCII_UNDERSCORE;
            tap_idx_d = '0;
            if (pend_vld_q) begin
              state_d     = ST_TAP;
              cand_key_d  = pend_key_q;
              cand_base_d = pend_base_q;
              cand_size_d = pend_size_q;
              preview_d   = pend_base_q;
              pend_vld_d  = 1'b0;
              idle_cnt_d  = '0;
            end else if (submit_after_q) begin
              state_d        = ST_WCOMMIT;
              submit_after_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end

        ST_WCOMMIT: begin
          if (word_ready) begin
            word_d  = '0;
            len_d   = '0;
            state_d = ST_IDLE;
          end
        end

        default: state_d = ST_IDLE;
      endcase

      if (do_commit) begin
        if (len_q == LW'(MAX_LEN)) begin
          // Buffer full: the candidate is silently dropped.
          state_d        = ST_IDLE;
          preview_d      = ASCII_UNDERSCORE;
          tap_idx_d      = '0;
          pend_vld_d     = 1'b0;
          submit_after_d = 1'b0;
        end else begin
          state_d  = ST_LCOMMIT;
          letter_d = cand_letter;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q        <= ST_IDLE;
      preview_q      <= ASCII_UNDERSCORE;
      letter_q       <= '0;
      word_q         <= '0;
      len_q          <= '0;
      game_end_q     <= 1'b0;
      idle_cnt_q     <= '0;
      cand_key_q     <= '0;
      cand_base_q    <= '0;
      cand_size_q    <= '0;
      tap_idx_q      <= '0;
      pend_vld_q     <= 1'b0;
      pend_key_q     <= '0;
      pend_base_q    <= '0;
      pend_size_q    <= '0;
      submit_after_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      preview_q      <= preview_d;
      letter_q       <= letter_d;
      word_q         <= word_d;
      len_q          <= len_d;
      game_end_q     <= game_end_d;
      idle_cnt_q     <= idle_cnt_d;
      cand_key_q     <= cand_key_d;
      cand_base_q    <= cand_base_d;
      cand_size_q    <= cand_size_d;
      tap_idx_q      <= tap_idx_d;
      pend_vld_q     <= pend_vld_d;
      pend_key_q     <= pend_key_d;
      pend_base_q    <= pend_base_d;
      pend_size_q    <= pend_size_d;
      submit_after_q <= submit_after_d;
    end
  end

  assign preview      = preview_q;
  assign letter       = letter_q;
  assign letter_valid = (state_q == ST_LCOMMIT);
  assign word_valid   = (state_q == ST_WCOMMIT);
  assign word         = word_q;
  assign word_len     = len_q;
  assign game_end     = game_end_q;

endmodule

// File: tb/tb_multitap_word_entry.sv
module tb_multitap_word_entry;

  localparam int TO = 16;
  localparam int ML = 2;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        strobe = 1'b0;
  logic [7:0]  cur_key = 8'h00;
  logic [7:0]  preview;
  logic        letter_valid;
  logic        letter_ready = 1'b0;
  logic [7:0]  letter;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic [15:0] word;
  logic [1:0]  word_len;
  logic        game_end;

  int n_tests = 0;
  int n_fail  = 0;
  int ge_seen = 0;

  logic [7:0]  exp_letter_q[$];
  logic [15:0] exp_word_q[$];
  logic [1:0]  exp_len_q[$];

  multitap_word_entry #(.TIMEOUT_CYCLES(TO), .MAX_LEN(ML)) dut (
    .clk          (clk),
    .nRst         (nRst),
    .strobe       (strobe),
    .cur_key      (cur_key),
    .preview      (preview),
    .letter_valid (letter_valid),
    .letter_ready (letter_ready),
    .letter       (letter),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .word         (word),
    .word_len     (word_len),
    .game_end     (game_end)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle strobe; returns one cycle after the sampling edge.
  task automatic press(input logic [7:0] key);
    @(posedge clk);
    #1;
    strobe  = 1'b1;
    cur_key = key;
    @(posedge clk);
    #1;
    strobe  = 1'b0;
    cur_key = 8'h00;
  endtask

  // Scoreboard monitor: compare every completed handshake against the queued expectation.
  always @(negedge clk) begin
    if (nRst) begin
      if (letter_valid && letter_ready) begin
        if (exp_letter_q.size() == 0) begin
          check("unexpected_letter", {24'h0, letter}, 32'hFFFF_FFFF);
        end else begin
          check("letter", {24'h0, letter}, {24'h0, exp_letter_q.pop_front()});
        end
      end
      if (word_valid && word_ready) begin
        if (exp_word_q.size() == 0) begin
          check("unexpected_word", {16'h0, word}, 32'hFFFF_FFFF);
        end else begin
          check("word", {16'h0, word}, {16'h0, exp_word_q.pop_front()});
          check("word_len_at_submit", {30'h0, word_len}, {30'h0, exp_len_q.pop_front()});
        end
      end
      if (game_end) ge_seen++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_preview", {24'h0, preview}, 32'h5F);
    check("rst_letter_valid", {31'h0, letter_valid}, 32'h0);
    check("rst_word_valid", {31'h0, word_valid}, 32'h0);
    check("rst_word_len", {30'h0, word_len}, 32'h0);
    check("rst_word", {16'h0, word}, 32'h0);
    check("rst_letter", {24'h0, letter}, 32'h0);
    check("rst_game_end", {31'h0, game_end}, 32'h0);
    nRst = 1'b1;
    tick();

    // ABC key tapped three times, then explicit commit
    letter_ready = 1'b1;
    press(8'h84); check("t1_preview_A", {24'h0, preview}, 32'h41);
    press(8'h84); check("t1_preview_B", {24'h0, preview}, 32'h42);
    press(8'h84); check("t1_preview_C", {24'h0, preview}, 32'h43);
    exp_letter_q.push_back(8'h43);
    press(8'h18);
    check("t1_letter_valid", {31'h0, letter_valid}, 32'h1);
    tick();
    check("t1_word_len", {30'h0, word_len}, 32'h1);
    check("t1_preview_after", {24'h0, preview}, 32'h5F);
    press(8'h14);
    check("t1_clear_len", {30'h0, word_len}, 32'h0);

    // WXYZ key five times wraps to W, then auto-commit after idle timeout
    letter_ready = 1'b0;
    repeat (5) press(8'h22);
    check("t2_preview_W", {24'h0, preview}, 32'h57);
    n = 0;
    while (!letter_valid && n < 40) begin
      tick();
      n++;
    end
    check("t2_timeout_cycles", n, TO);
    check("t2_letter_held", {24'h0, letter}, 32'h57);
    exp_letter_q.push_back(8'h57);
    letter_ready = 1'b1;
    tick();
    tick();
    check("t2_word_len", {30'h0, word_len}, 32'h1);
    press(8'h14);

    // J then M with letter_ready held low for three cycles
    letter_ready = 1'b0;
    press(8'h44);
    press(8'h42);
    for (int i = 0; i < 3; i++) begin
      check("t3_valid_held", {31'h0, letter_valid}, 32'h1);
      check("t3_letter_J", {24'h0, letter}, 32'h4A);
      tick();
    end
    exp_letter_q.push_back(8'h4A);
    letter_ready = 1'b1;
    tick();
    check("t3_preview_M", {24'h0, preview}, 32'h4D);
    check("t3_word_len", {30'h0, word_len}, 32'h1);
    check("t3_valid_dropped", {31'h0, letter_valid}, 32'h0);
    press(8'h14);

    // Fill a two-letter buffer, overflow is dropped, then submit
    exp_letter_q.push_back(8'h41);
    press(8'h84); press(8'h18); tick();
    exp_letter_q.push_back(8'h44);
    press(8'h82); press(8'h18); tick();
    check("t4_len_full", {30'h0, word_len}, 32'h2);
    press(8'h48);
    check("t4_preview_G", {24'h0, preview}, 32'h47);
    press(8'h18);
    check("t4_no_letter_valid", {31'h0, letter_valid}, 32'h0);
    check("t4_len_still_2", {30'h0, word_len}, 32'h2);
    check("t4_preview_reset", {24'h0, preview}, 32'h5F);
    exp_word_q.push_back(16'h4441);
    exp_len_q.push_back(2'd2);
    word_ready = 1'b1;
    press(8'h12);
    check("t4_word_valid", {31'h0, word_valid}, 32'h1);
    tick();
    check("t4_len_cleared", {30'h0, word_len}, 32'h0);
    check("t4_word_cleared", {16'h0, word}, 32'h0);
    word_ready = 1'b0;

    // Backspace on "AD", then game end
    exp_letter_q.push_back(8'h41);
    press(8'h84); press(8'h18); tick();
    exp_letter_q.push_back(8'h44);
    press(8'h82); press(8'h18); tick();
    press(8'h11);
    check("t5_bksp_len", {30'h0, word_len}, 32'h1);
    check("t5_bksp_hi", {24'h0, word[15:8]}, 32'h0);
    check("t5_bksp_lo", {24'h0, word[7:0]}, 32'h41);
    press(8'h21);
    check("t5_game_end_hi", {31'h0, game_end}, 32'h1);
    check("t5_end_len", {30'h0, word_len}, 32'h0);
    check("t5_end_preview", {24'h0, preview}, 32'h5F);
    tick();
    check("t5_game_end_lo", {31'h0, game_end}, 32'h0);

    // Ignored codes and edge commands
    press(8'hC4);
    check("t6_non_onehot", {24'h0, preview}, 32'h5F);
    press(8'h88);
    check("t6_unmapped", {24'h0, preview}, 32'h5F);
    press(8'h12);
    check("t6_submit_empty", {31'h0, word_valid}, 32'h0);
    press(8'h11);
    check("t6_bksp_empty", {30'h0, word_len}, 32'h0);
    press(8'h24);
    check("t6_preview_T", {24'h0, preview}, 32'h54);
    press(8'h11);
    check("t6_bksp_tap", {24'h0, preview}, 32'h5F);
    check("t6_bksp_tap_valid", {31'h0, letter_valid}, 32'h0);

    repeat (3) tick();
    check("sb_letters_drained", exp_letter_q.size(), 0);
    check("sb_words_drained", exp_word_q.size(), 0);
    check("game_end_pulses", ge_seen, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multitap_word_entry.md
MULTITAP_WORD_ENTRY -- requirements
Module: multitap_word_entry

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 50_000_000, idle cycles in TAP before a candidate auto-commits; 0 disables auto-commit.
REQ-002 The block SHALL have parameter MAX_LEN, default 8, word buffer depth in letters, range 1..16.
REQ-003 The block SHALL have port clk, input, 1, clock.
REQ-004 The block SHALL have port nRst, input, 1, reset, asynchronous, active-low.
REQ-005 The block SHALL have port strobe, input, 1, one-cycle key-press pulse; cur_key is sampled only when strobe=1.
REQ-006 The block SHALL have port cur_key, input, 8, {row[3:0], col[3:0]}, one-hot each, with row0=4'b1000 and col0=4'b1000.
REQ-007 The block SHALL have port preview, output, 8, current candidate ASCII, or 0x5F ('_') when no candidate exists.
REQ-008 The block SHALL have ports letter_valid (output, 1), letter_ready (input, 1) and letter (output, 8): committed-letter handshake.
REQ-009 The block SHALL have ports word_valid (output, 1), word_ready (input, 1), word (output, 8*MAX_LEN) and word_len (output, $clog2(MAX_LEN+1)): submitted-word handshake.
REQ-010 The block SHALL have port game_end, output, 1, one-cycle pulse.

Function
REQ-011 Key map SHALL be: R0C1=ABC, R0C2=DEF, R1C0=GHI, R1C1=JKL, R1C2=MNO, R2C0=PQRS, R2C1=TUV, R2C2=WXYZ, R3C0=commit letter, R3C1=clear, R3C2=submit word, R2C3=game end, R3C3=backspace; all other codes, including non-one-hot codes, SHALL be ignored.
REQ-012 The state machine SHALL have states IDLE, TAP, LCOMMIT and WCOMMIT.
REQ-013 In IDLE, a letter key SHALL enter TAP with tap index 0; preview = base letter one cycle after the strobe.
REQ-014 In TAP, a repeat of the same letter key SHALL advance the tap index modulo the set size (3 or 4), so a 4th press on a 3-letter key returns to the first letter.
REQ-015 In TAP, a different letter key SHALL commit the current candidate (enter LCOMMIT) and latch the new key as pending; after the handshake the block SHALL enter TAP with the pending key at index 0.
REQ-016 In TAP, a commit-letter key, or the idle counter reaching TIMEOUT_CYCLES-1, SHALL enter LCOMMIT; the idle counter SHALL reset on every accepted strobe.
REQ-017 In LCOMMIT, letter_valid SHALL be 1 and letter stable until the cycle with letter_ready=1; on that cycle the letter SHALL be appended at word[8*len +: 8], len incremented, and preview reset to 0x5F.
REQ-018 If len==MAX_LEN at commit, the candidate SHALL be dropped with no handshake and the block SHALL return to IDLE.
REQ-019 In TAP, backspace SHALL cancel the candidate and return to IDLE; in IDLE, backspace SHALL zero the last letter and decrement len if len>0, otherwise do nothing.
REQ-020 Submit-word in IDLE with len>0 SHALL enter WCOMMIT; with len==0 it SHALL be ignored; in TAP it SHALL commit the candidate first, then enter WCOMMIT after the letter handshake.
REQ-021 In WCOMMIT, word_valid SHALL be 1 until word_ready; on acceptance word and len SHALL be cleared and the block SHALL return to IDLE.
REQ-022 Clear, from any state, SHALL empty buffer, candidate and pending key, deassert valids and enter IDLE next cycle; game end SHALL do the same and pulse game_end for exactly one cycle.
REQ-023 Strobes other than clear and game end SHALL be ignored in LCOMMIT and WCOMMIT.
REQ-024 Unused word bytes SHALL read 0x00.

Reset
REQ-025 On nRst=0 the block SHALL set state IDLE, preview=0x5F, letter=0, letter_valid=0, word=0, word_len=0, word_valid=0, game_end=0, idle counter=0 and pending key cleared; reset mid-handshake SHALL discard the transfer.

Structure
REQ-026 Package keypad_pkg SHALL hold key-code constants, the state enum, the ASCII underscore constant and the key-to-base-letter/set-size table.
REQ-027 Sub-module keypad_tap_decode (combinational: cur_key -> is_letter, base ASCII, set size, command code) SHALL be instantiated once.

Verification
REQ-028 R0C1 x3 then R3C0, letter_ready=1 -> preview 'A','B','C'; letter=0x43 handshake; word_len=1.
REQ-029 R2C2 x5, then idle TIMEOUT_CYCLES (bench uses 16) -> letter=0x57 ('W', wrapped), auto-committed.
REQ-030 R1C1 then R1C2, letter_ready held 0 for 3 cycles -> letter_valid holds 'J' 3 cycles; after acceptance, preview='M'.
REQ-031 MAX_LEN=2: commit 'A','D', press R1C0 and commit -> no letter_valid, word_len stays 2; R3C2 with word_ready=1 -> word=0x4441, then word_len=0.
REQ-032 Buffer "AD": R3C3 -> word_len=1, word[15:8]=0x00; R2C3 -> game_end pulse of one cycle, word_len=0, preview=0x5F.
